// File: rtl/frog_position_ctrl.sv
// frog_position_ctrl
// Tracks the frog's (X, Y) cell on the Frogger playfield. It takes the
// one-cycle direction pulses, clamps moves at the playfield edges, and holds
// off further moves for a short time after each accepted move. It also
// detects the goal row and counts the score, and turns collision edges into
// lost lives and game over.

module frog_position_ctrl #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int XW          = 3,
    parameter int YW          = 3,
    parameter int START_X     = 3,
    parameter int START_Y     = 0,
    parameter int LIVES       = 3,
    parameter int LOCK_CYCLES = 4
) (
    input  logic          FP_CLOCK_50,
    input  logic          FP_RESET,
    input  logic          FP_UP,
    input  logic          FP_DOWN,
    input  logic          FP_LEFT,
    input  logic          FP_RIGHT,
    input  logic          FP_HIT,
    output logic [XW-1:0] FP_X,
    output logic [YW-1:0] FP_Y,
    output logic [1:0]    FP_LIVES,
    output logic [3:0]    FP_SCORE,
    output logic          FP_WIN,
    output logic          FP_OVER
);

    typedef enum logic [1:0] {PLAY, LOCK, WIN, OVER} state_t;

    localparam int            CW         = $clog2(LOCK_CYCLES + 1);
    localparam logic [XW-1:0] X_START    = XW'(START_X);
    localparam logic [XW-1:0] X_MAX      = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_START    = YW'(START_Y);
    localparam logic [YW-1:0] Y_GOAL     = YW'(ROWS - 1);
    localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCK_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    lives_q, lives_d;
    logic [3:0]    score_q, score_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          hit_prev_q;
    logic          hit_event;
    logic          move_ok;
    logic [XW-1:0] move_x;
    logic [YW-1:0] move_y;

    // A collision is counted once per rising edge, however long it is held.
    assign hit_event = FP_HIT & ~hit_prev_q;

    // Find the winning direction (UP > DOWN > LEFT > RIGHT) and the cell it
    // would lead to. Moves that would leave the playfield are not legal.
    always_comb begin
        move_ok = 1'b0;
        move_x  = x_q;
        move_y  = y_q;
        if (FP_UP) begin
            move_ok = (y_q != Y_GOAL);
            move_y  = y_q + YW'(1);
        end else if (FP_DOWN) begin
            move_ok = (y_q != '0);
            move_y  = y_q - YW'(1);
        end else if (FP_LEFT) begin
            move_ok = (x_q != '0);
            move_x  = x_q - XW'(1);
        end else if (FP_RIGHT) begin
            move_ok = (x_q != X_MAX);
            move_x  = x_q + XW'(1);
        end
    end

    // Compute the next state and the next datapath values. A hit in PLAY or
    // LOCK always wins over moves and over the lockout countdown.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        lives_d    = lives_q;
        score_d    = score_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            PLAY, LOCK: begin
                if (hit_event) begin
                    x_d = X_START;
                    y_d = Y_START;
                    if (lives_q == 2'd1) begin
                        lives_d = 2'd0;
                        state_d = OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = PLAY;
                    end
                end else if (state_q == PLAY) begin
                    if (move_ok) begin
                        x_d = move_x;
                        y_d = move_y;
                        if (move_y == Y_GOAL) begin
                            state_d = WIN;
                        end else begin
                            lock_cnt_d = LOCK_LOAD;
                            state_d    = LOCK;
                        end
                    end
                end else if (lock_cnt_q == '0) begin
                    state_d = PLAY;
                end else begin
                    lock_cnt_d = lock_cnt_q - CW'(1);
                end
            end
            WIN: begin
                x_d     = X_START;
                y_d     = Y_START;
                score_d = score_q + 4'd1;
                state_d = PLAY;
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers, restored as a group by the synchronous reset.
    always_ff @(posedge FP_CLOCK_50) begin
        if (FP_RESET) begin
            state_q    <= PLAY;
            x_q        <= X_START;
            y_q        <= Y_START;
            lives_q    <= LIVES_INIT;
            score_q    <= 4'd0;
            lock_cnt_q <= '0;
            hit_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            lock_cnt_q <= lock_cnt_d;
            hit_prev_q <= FP_HIT;
        end
    end

    assign FP_X     = x_q;
    assign FP_Y     = y_q;
    assign FP_LIVES = lives_q;
    assign FP_SCORE = score_q;
    assign FP_WIN   = (state_q == WIN);
    assign FP_OVER  = (state_q == OVER);

endmodule

// File: tb/tb_frog_position_ctrl.sv
// tb_frog_position_ctrl
// Directed bench for frog_position_ctrl with the default parameters (8x8
// field, spawn (3,0), 3 lives, 4-cycle lockout). Inputs change 1ns after a
// rising edge, and outputs are read at the same point.

module tb_frog_position_ctrl;

    localparam logic [3:0] D_UP    = 4'b1000;
    localparam logic [3:0] D_DOWN  = 4'b0100;
    localparam logic [3:0] D_LEFT  = 4'b0010;
    localparam logic [3:0] D_RIGHT = 4'b0001;
    localparam logic [3:0] D_NONE  = 4'b0000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, hit = 1'b0;
    logic [2:0] fx, fy;
    logic [1:0] lives;
    logic [3:0] score;
    logic       win, over;

    int compare_count  = 0;
    int mismatch_count = 0;

    frog_position_ctrl dut (
        .FP_CLOCK_50 (clk),
        .FP_RESET    (rst),
        .FP_UP       (up),
        .FP_DOWN     (down),
        .FP_LEFT     (left),
        .FP_RIGHT    (right),
        .FP_HIT      (hit),
        .FP_X        (fx),
        .FP_Y        (fy),
        .FP_LIVES    (lives),
        .FP_SCORE    (score),
        .FP_WIN      (win),
        .FP_OVER     (over)
    );

    // 50 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compare_count++;
        if (observed != expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n clock edges, landing 1ns after the last one.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present direction pulses and a hit level for exactly one sampling edge.
    task automatic applyStimulus(input logic [3:0] dirs, input logic hit_lvl);
        {up, down, left, right} = dirs;
        hit = hit_lvl;
        idle(1);
        {up, down, left, right} = D_NONE;
        hit = 1'b0;
    endtask

    // Accepted move followed by enough idle edges to clear the lockout.
    task automatic moveAndSettle(input logic [3:0] dirs);
        applyStimulus(dirs, 1'b0);
        idle(4);
    endtask

    // One-cycle reset, then confirm the full reset state.
    task automatic doReset(input string tag);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput({tag, "_x"}, fx, 3);
        checkOutput({tag, "_y"}, fy, 0);
        checkOutput({tag, "_lives"}, lives, 3);
        checkOutput({tag, "_score"}, score, 0);
        checkOutput({tag, "_win"}, win, 0);
        checkOutput({tag, "_over"}, over, 0);
    endtask

    initial begin
        #2;
        doReset("rst0");

        // Lockout: RIGHT accepted, RIGHT 2 cycles later dropped, RIGHT 5 cycles later accepted.
        applyStimulus(D_RIGHT, 1'b0);
        checkOutput("lock_first", fx, 4);
        idle(1);
        applyStimulus(D_RIGHT, 1'b0);
        checkOutput("lock_dropped", fx, 4);
        idle(2);
        applyStimulus(D_RIGHT, 1'b0);
        checkOutput("lock_release", fx, 5);
        idle(4);

        // Walk to the left edge, then check clamping and the absence of lockout.
        repeat (5) moveAndSettle(D_LEFT);
        checkOutput("left_walk", fx, 0);
        applyStimulus(D_LEFT, 1'b0);
        checkOutput("left_clamp", fx, 0);
        applyStimulus(D_RIGHT, 1'b0);
        checkOutput("right_after_clamp", fx, 1);
        idle(4);

        // Right edge and bottom edge clamping.
        repeat (6) moveAndSettle(D_RIGHT);
        checkOutput("right_walk", fx, 7);
        applyStimulus(D_RIGHT, 1'b0);
        checkOutput("right_clamp", fx, 7);
        applyStimulus(D_DOWN, 1'b0);
        checkOutput("down_clamp", fy, 0);

        // Priority: UP beats LEFT, then DOWN beats LEFT.
        doReset("rst1");
        applyStimulus(D_UP | D_LEFT, 1'b0);
        checkOutput("prio_up_x", fx, 3);
        checkOutput("prio_up_y", fy, 1);
        idle(4);
        applyStimulus(D_DOWN | D_LEFT | D_RIGHT, 1'b0);
        checkOutput("prio_down_x", fx, 3);
        checkOutput("prio_down_y", fy, 0);
        idle(4);

        // First goal: seven UPs spaced 6 cycles apart.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(D_UP, 1'b0);
            if (i < 6) idle(5);
        end
        checkOutput("goal_y", fy, 7);
        checkOutput("goal_x", fx, 3);
        checkOutput("goal_win", win, 1);
        applyStimulus(D_RIGHT, 1'b1);
        checkOutput("goal_win_drop", win, 0);
        checkOutput("goal_ret_x", fx, 3);
        checkOutput("goal_ret_y", fy, 0);
        checkOutput("goal_score", score, 1);
        checkOutput("goal_hit_ignored", lives, 3);

        // Fifteen more goals take the score around to 0.
        for (int g = 0; g < 15; g++) begin
            for (int i = 0; i < 7; i++) begin
                applyStimulus(D_UP, 1'b0);
                if (i < 6) idle(5);
            end
            idle(1);
            if (g == 13) checkOutput("score_15", score, 15);
        end
        checkOutput("score_wrap", score, 0);

        // Hits: a held level costs one life, then two pulses lead to game over.
        doReset("rst2");
        repeat (2) moveAndSettle(D_RIGHT);
        repeat (4) moveAndSettle(D_UP);
        checkOutput("pre_hit_x", fx, 5);
        checkOutput("pre_hit_y", fy, 4);
        hit = 1'b1;
        idle(1);
        checkOutput("hit1_lives", lives, 2);
        checkOutput("hit1_x", fx, 3);
        checkOutput("hit1_y", fy, 0);
        idle(9);
        hit = 1'b0;
        checkOutput("hit_held_once", lives, 2);
        idle(1);
        applyStimulus(D_NONE, 1'b1);
        checkOutput("hit2_lives", lives, 1);
        checkOutput("hit2_over", over, 0);
        idle(1);
        applyStimulus(D_UP, 1'b1);
        checkOutput("hit3_lives", lives, 0);
        checkOutput("hit3_over", over, 1);
        checkOutput("hit3_y", fy, 0);
        applyStimulus(D_RIGHT, 1'b0);
        applyStimulus(D_UP, 1'b0);
        checkOutput("over_x", fx, 3);
        checkOutput("over_y", fy, 0);
        checkOutput("over_held", over, 1);

        // Reset out of OVER, then a move must be taken straight away.
        doReset("rst3");
        applyStimulus(D_RIGHT, 1'b0);
        checkOutput("post_over_move", fx, 4);

        // Reset in the middle of a lockout clears the counter.
        idle(1);
        doReset("rst4");
        applyStimulus(D_RIGHT, 1'b0);
        checkOutput("post_lock_move", fx, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

    // Hard stop so the bench cannot run away.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
